// File: rtl/fifo_fwft_adapter_pkg.sv
// Shared constants for the lookahead read adapter: buffer depth and occupancy states.
// Defining PRGA_FWFT_ADAPTER_REGRD_EN selects the three-entry variant whose issue logic ignores rd.
package fifo_fwft_adapter_pkg;

`ifdef PRGA_FWFT_ADAPTER_REGRD_EN
  localparam int unsigned DEPTH = 3;
`else
  localparam int unsigned DEPTH = 2;
`endif

  localparam int unsigned CNT_W = 2;
  localparam int unsigned IDX_W = (DEPTH > 2) ? 2 : 1;

  typedef logic [CNT_W-1:0] count_t;

  localparam count_t EMPTY = CNT_W'(0);
  localparam count_t ONE   = CNT_W'(1);
  localparam count_t FULL  = CNT_W'(DEPTH);

endpackage

// File: rtl/fifo_fwft_adapter_skid.sv
// Head-plus-tail word store: entry 0 is the visible head, higher entries are skid slots.
// A shift moves every entry one step toward the head; a write lands in a chosen slot.
module fifo_fwft_adapter_skid
  import fifo_fwft_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_shift,
  input  logic                  i_wr,
  input  logic [IDX_W-1:0]      i_wr_idx,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DEPTH-1:0][DATA_WIDTH-1:0] r_entry;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] w_entry_nxt;

  // Shift first, then the arriving word overwrites its target slot.
  always_comb begin
    w_entry_nxt = r_entry;
    if (i_shift) begin
      w_entry_nxt = {r_entry[DEPTH-1], r_entry[DEPTH-1:1]};
    end
    if (i_wr) begin
      w_entry_nxt[i_wr_idx] = i_din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_entry <= '0;
    end else begin
      r_entry <= w_entry_nxt;
    end
  end

  assign o_head = r_entry[0];

endmodule

// File: rtl/fifo_fwft_adapter.sv
// Converts a non-lookahead FIFO read port into a first-word-fall-through port with prefetch.
// Build option PRGA_FWFT_ADAPTER_REGRD_EN: three-entry buffer, upstream read independent of rd.
module fifo_fwft_adapter
  import fifo_fwft_adapter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty_i,
  output logic                  rd_i,
  input  logic [DATA_WIDTH-1:0] dout_i,
  output logic                  empty,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] dout
);

  localparam int unsigned SUM_W = CNT_W + 1;

  count_t                  r_count;
  count_t                  w_count_nxt;
  logic                    r_inflight;
  logic                    r_empty;
  logic                    w_pop;
  logic                    w_arrive;
  logic                    w_credit;
  logic                    w_shift;
  logic                    w_wr;
  logic [IDX_W-1:0]        w_wr_idx;
  logic [SUM_W-1:0]        w_load;
  logic [DATA_WIDTH-1:0]   w_head;

  assign w_pop    = rd & ~r_empty;
  assign w_arrive = r_inflight;

  // Slots already committed (held or in flight); a read may issue only if one stays free.
`ifdef PRGA_FWFT_ADAPTER_REGRD_EN
  assign w_load = SUM_W'(r_count) + SUM_W'(r_inflight);
`else
  assign w_load = SUM_W'(r_count) + SUM_W'(r_inflight) - SUM_W'(w_pop);
`endif

  assign w_credit = (w_load < SUM_W'(FULL));
  assign rd_i     = rst & ~empty_i & w_credit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count    <= EMPTY;
      r_inflight <= 1'b0;
      r_empty    <= 1'b1;
    end else begin
      r_count    <= w_count_nxt;
      r_inflight <= rd_i;
      r_empty    <= (w_count_nxt == EMPTY);
    end
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_arrive, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Arrivals fill the first free slot as seen after this cycle's pop.
  always_comb begin
    w_shift  = 1'b0;
    w_wr     = w_arrive;
    w_wr_idx = '0;
    case (r_count)
      EMPTY: w_wr_idx = '0;
      ONE:   w_wr_idx = IDX_W'(~w_pop);
      default: begin
        w_shift  = w_pop;
        w_wr_idx = IDX_W'(r_count - CNT_W'(w_pop));
      end
    endcase
  end

  fifo_fwft_adapter_skid #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .i_shift  (w_shift),
    .i_wr     (w_wr),
    .i_wr_idx (w_wr_idx),
    .i_din    (dout_i),
    .o_head   (w_head)
  );

  assign empty = r_empty;
  assign dout  = w_head;

endmodule

// File: tb/tb_fifo_fwft_adapter.sv
// Directed bench for fifo_fwft_adapter: per-cycle vector table plus streaming,
// backpressure and mid-flight reset sequences against a behavioural upstream FIFO.
module tb_fifo_fwft_adapter;
  import fifo_fwft_adapter_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned NV = 31;

  typedef struct {
    logic          rst;
    logic          ei;
    logic          rd;
    logic          x_rdi;
    logic          x_empty;
    logic [DW-1:0] x_dout;
  } vec_t;

  vec_t tv [NV];
  int   nfill = 0;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          up_gate = 1'b1;
  logic          rd = 1'b0;
  logic          rd_i;
  logic          empty_i;
  logic          empty;
  logic [DW-1:0] dout_i = '0;
  logic [DW-1:0] dout;

  logic [DW-1:0] up_mem [256];
  int unsigned   up_ptr = 0;
  int unsigned   up_lim = 0;
  int            occ = 0;
  int            n_vec = 0;
  int            n_err = 0;

  fifo_fwft_adapter #(.DATA_WIDTH(DW)) dut (
    .clk     (clk),
    .rst     (rst),
    .empty_i (empty_i),
    .rd_i    (rd_i),
    .dout_i  (dout_i),
    .empty   (empty),
    .rd      (rd),
    .dout    (dout)
  );

  always #5 clk = ~clk;

  // Upstream non-lookahead FIFO: data appears the cycle after a read strobe.
  assign empty_i = up_gate | (up_ptr >= up_lim);
  always @(posedge clk) begin
    if (rd_i) begin
      dout_i <= up_mem[up_ptr % 256];
      up_ptr <= up_ptr + 1;
    end
  end

  // Words held or in flight inside the adapter.
  always @(posedge clk or negedge rst) begin
    if (!rst) occ <= 0;
    else      occ <= occ + int'(rd_i) - int'(rd & ~empty);
  end

  function automatic logic [DW-1:0] w(input int n);
    return 32'hA5A5_0001 + 32'(n);
  endfunction

  task automatic add(input logic r, input logic e, input logic d,
                     input logic xr, input logic xe, input logic [DW-1:0] xd);
    tv[nfill] = '{rst: r, ei: e, rd: d, x_rdi: xr, x_empty: xe, x_dout: xd};
    nfill++;
  endtask

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic mon();
    n_vec++;
    if (rd_i && empty_i) begin
      n_err++;
      $display("FAIL rd_i_while_upstream_empty: got 1 expected 0");
    end
    n_vec++;
    if (occ > int'(DEPTH)) begin
      n_err++;
      $display("FAIL occupancy: got %0d expected <= %0d", occ, DEPTH);
    end
  endtask

  task automatic wait_nonempty(input string nm);
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 10 && !ok; t++) begin
      @(negedge clk);
      mon();
      if (!empty) ok = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk({nm, ".fill_timeout"}, 32'(ok), 32'd1);
  endtask

  initial begin
    int unsigned base;
    int          expk;
    logic [DW-1:0] exp_next;
    bit          found;

    for (int i = 0; i < 256; i++) up_mem[i] = w(i);
    up_lim = 64;

    add(0,0,0, 0,1,'0); add(0,0,0, 0,1,'0); add(0,0,0, 0,1,'0);
`ifdef PRGA_FWFT_ADAPTER_REGRD_EN
    add(1,0,0, 1,1,'0);   add(1,0,0, 1,1,'0);   add(1,0,0, 1,0,w(0));
    add(1,0,0, 0,0,w(0)); add(1,0,0, 0,0,w(0)); add(1,0,1, 0,0,w(0));
    add(1,0,1, 1,0,w(1)); add(1,0,1, 1,0,w(2)); add(1,0,1, 1,0,w(3));
    add(1,0,1, 1,0,w(4)); add(1,0,0, 1,0,w(5)); add(1,0,1, 0,0,w(5));
    add(1,0,0, 1,0,w(6)); add(1,0,1, 0,0,w(6)); add(1,0,0, 1,0,w(7));
    add(1,1,1, 0,0,w(7)); add(1,1,1, 0,0,w(8)); add(1,1,1, 0,0,w(9));
    add(1,1,1, 0,1,w(9)); add(1,0,1, 1,1,w(9)); add(1,0,1, 1,1,w(9));
    add(1,0,0, 1,0,w(10)); add(1,0,1, 0,0,w(10));
    add(0,0,0, 0,1,'0);   add(0,0,0, 0,1,'0);
    add(1,0,0, 1,1,'0);   add(1,0,0, 1,1,'0);   add(1,0,0, 1,0,w(13));
`else
    add(1,0,0, 1,1,'0);   add(1,0,0, 1,1,'0);   add(1,0,0, 0,0,w(0));
    add(1,0,0, 0,0,w(0)); add(1,0,0, 0,0,w(0)); add(1,0,1, 1,0,w(0));
    add(1,0,1, 1,0,w(1)); add(1,0,1, 1,0,w(2)); add(1,0,1, 1,0,w(3));
    add(1,0,1, 1,0,w(4)); add(1,0,0, 0,0,w(5)); add(1,0,1, 1,0,w(5));
    add(1,0,0, 0,0,w(6)); add(1,0,1, 1,0,w(6)); add(1,0,0, 0,0,w(7));
    add(1,1,1, 0,0,w(7)); add(1,1,1, 0,0,w(8)); add(1,1,1, 0,1,w(8));
    add(1,1,1, 0,1,w(8)); add(1,0,1, 1,1,w(8)); add(1,0,1, 1,1,w(8));
    add(1,0,0, 0,0,w(9)); add(1,0,1, 1,0,w(9));
    add(0,0,0, 0,1,'0);   add(0,0,0, 0,1,'0);
    add(1,0,0, 1,1,'0);   add(1,0,0, 1,1,'0);   add(1,0,0, 0,0,w(12));
`endif

    // Cycle-accurate table: drive after the edge, check on the falling edge.
    for (int k = 0; k < NV; k++) begin
      rst     = tv[k].rst;
      up_gate = tv[k].ei;
      rd      = tv[k].rd;
      @(negedge clk);
      chk($sformatf("v%0d.rd_i", k),  32'(rd_i),  32'(tv[k].x_rdi));
      chk($sformatf("v%0d.empty", k), 32'(empty), 32'(tv[k].x_empty));
      chk($sformatf("v%0d.dout", k),  dout,       tv[k].x_dout);
      mon();
      @(posedge clk); #1;
    end

    // Reset right after an issued read: the in-flight word is lost.
    rst = 1'b1; up_gate = 1'b0; rd = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 10 && !found; t++) begin
      @(negedge clk);
      mon();
      if (rd_i) found = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst.issue_seen", 32'(found), 32'd1);
    rst = 1'b0;
    exp_next = up_mem[up_ptr % 256];
    @(negedge clk);
    chk("midrst.empty", 32'(empty), 32'd1);
    chk("midrst.dout",  dout,       '0);
    chk("midrst.rd_i",  32'(rd_i),  32'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1; rd = 1'b0;
    wait_nonempty("midrst");
    chk("midrst.next_word", dout, exp_next);
    @(posedge clk); #1;

    // Streaming 0..15 with rd held high: no bubbles once the head fills.
    rst = 1'b0; up_gate = 1'b1; rd = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    base = up_ptr;
    for (int k = 0; k < 16; k++) up_mem[(base + k) % 256] = 32'(k);
    up_lim = base + 16;
    up_gate = 1'b0; rst = 1'b1; rd = 1'b1;
    wait_nonempty("stream");
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("stream%0d.empty", k), 32'(empty), 32'd0);
      chk($sformatf("stream%0d.dout", k),  dout,       32'(k));
      mon();
      @(posedge clk); #1;
      @(negedge clk);
    end
    chk("stream.drained", 32'(empty), 32'd1);
    @(posedge clk); #1;

    // Backpressure: consumer pops every other cycle; order must be preserved.
    base = up_ptr;
    for (int k = 0; k < 24; k++) up_mem[(base + k) % 256] = 32'(100 + k);
    up_lim = base + 24;
    expk = 0;
    for (int t = 0; t < 200 && expk < 24; t++) begin
      rd = (t % 2 == 0);
      @(negedge clk);
      mon();
      if (rd && !empty) begin
        chk($sformatf("bp%0d.dout", expk), dout, 32'(100 + expk));
        expk++;
      end
      @(posedge clk); #1;
    end
    chk("bp.delivered", 32'(expk), 32'd24);
    rd = 1'b0;
    @(negedge clk);
    chk("bp.drained", 32'(empty), 32'd1);
    mon();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
